// File: rtl/dwt_band_feature_engine.sv
// Streaming LEVELS-deep Haar cascade with per-band max/min/sum/mean features.
// Optional macro DWT_ABS_SUM_EN adds a per-band sum of |coef| output.
module dwt_band_feature_engine #(
  parameter int DATA_W   = 32,
  parameter int LEVELS   = 4,
  parameter int WIN_LOG2 = 7,
  parameter int SUM_W    = DATA_W + WIN_LOG2,
  localparam int BAND_W  = $clog2(LEVELS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BAND_W-1:0]        out_band,
  output logic signed [DATA_W-1:0] out_max,
  output logic signed [DATA_W-1:0] out_min,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic signed [DATA_W-1:0] out_mean,
  output logic                     out_last
`ifdef DWT_ABS_SUM_EN
  ,
  output logic [SUM_W-1:0]         out_abs_sum
`endif
);

  localparam int NUM_BANDS = LEVELS + 1;

  typedef enum logic [1:0] {ACCUM, SETTLE, READOUT} state_t;

  state_t state, state_nxt;
  logic [WIN_LOG2-1:0] smp_cnt;
  logic [BAND_W-1:0]   settle_cnt;
  logic                accept, beat_done, frame_done;

  assign accept     = in_valid && in_ready;
  assign beat_done  = out_valid && out_ready;
  assign frame_done = beat_done && out_last;

  // ---------------- Haar cascade ----------------
  logic signed [DATA_W-1:0] st_in   [LEVELS];
  logic                     st_in_v [LEVELS];
  logic signed [DATA_W-1:0] st_hold [LEVELS];
  logic                     st_ph   [LEVELS];
  logic signed [DATA_W-1:0] st_a    [LEVELS];
  logic signed [DATA_W-1:0] st_d    [LEVELS];
  logic                     st_v    [LEVELS];
  logic [DATA_W:0]          sum_w   [LEVELS];
  logic [DATA_W:0]          dif_w   [LEVELS];

  always_comb begin
    st_in[0]   = in_data;
    st_in_v[0] = accept;
    for (int unsigned l = 1; l < LEVELS; l++) begin
      st_in[l]   = st_a[l-1];
      st_in_v[l] = st_v[l-1];
    end
    // Bits [DATA_W:1] of the DATA_W+1 result are the floor-shifted value truncated to DATA_W.
    for (int unsigned l = 0; l < LEVELS; l++) begin
      sum_w[l] = {st_hold[l][DATA_W-1], st_hold[l]} + {st_in[l][DATA_W-1], st_in[l]};
      dif_w[l] = {st_hold[l][DATA_W-1], st_hold[l]} - {st_in[l][DATA_W-1], st_in[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      for (int unsigned l = 0; l < LEVELS; l++) begin
        st_hold[l] <= '0;
        st_ph[l]   <= 1'b0;
        st_a[l]    <= '0;
        st_d[l]    <= '0;
        st_v[l]    <= 1'b0;
      end
    end else begin
      for (int unsigned l = 0; l < LEVELS; l++) begin
        st_v[l] <= 1'b0;
        if (st_in_v[l]) begin
          if (!st_ph[l]) begin
            st_hold[l] <= st_in[l];
            st_ph[l]   <= 1'b1;
          end else begin
            st_ph[l] <= 1'b0;
            st_a[l]  <= sum_w[l][DATA_W:1];
            st_d[l]  <= dif_w[l][DATA_W:1];
            st_v[l]  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- Per-band accumulators ----------------
  logic signed [DATA_W-1:0] bc     [NUM_BANDS];
  logic                     bv     [NUM_BANDS];
  logic signed [DATA_W-1:0] acc_max[NUM_BANDS];
  logic signed [DATA_W-1:0] acc_min[NUM_BANDS];
  logic signed [SUM_W-1:0]  acc_sum[NUM_BANDS];
  logic                     acc_seen[NUM_BANDS];

  always_comb begin
    for (int unsigned k = 0; k < LEVELS; k++) begin
      bc[k] = st_d[k];
      bv[k] = st_v[k];
    end
    bc[LEVELS] = st_a[LEVELS-1];
    bv[LEVELS] = st_v[LEVELS-1];
  end

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
        acc_max[k]  <= '0;
        acc_min[k]  <= '0;
        acc_sum[k]  <= '0;
        acc_seen[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
        if (bv[k]) begin
          acc_seen[k] <= 1'b1;
          if (!acc_seen[k]) begin
            acc_max[k] <= bc[k];
            acc_min[k] <= bc[k];
            acc_sum[k] <= SUM_W'(bc[k]);
          end else begin
            if (bc[k] > acc_max[k]) acc_max[k] <= bc[k];
            if (bc[k] < acc_min[k]) acc_min[k] <= bc[k];
            acc_sum[k] <= acc_sum[k] + SUM_W'(bc[k]);
          end
        end
      end
    end
  end

`ifdef DWT_ABS_SUM_EN
  logic [DATA_W-1:0] bc_abs [NUM_BANDS];
  logic [SUM_W-1:0]  acc_abs[NUM_BANDS];

  always_comb begin
    for (int unsigned k = 0; k < NUM_BANDS; k++) begin
      if (bc[k] == {1'b1, {(DATA_W-1){1'b0}}})
        bc_abs[k] = {1'b0, {(DATA_W-1){1'b1}}};
      else if (bc[k][DATA_W-1])
        bc_abs[k] = -bc[k];
      else
        bc_abs[k] = bc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) acc_abs[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
        if (bv[k]) begin
          if (!acc_seen[k]) acc_abs[k] <= SUM_W'(bc_abs[k]);
          else              acc_abs[k] <= acc_abs[k] + SUM_W'(bc_abs[k]);
        end
      end
    end
  end
`endif

  // ---------------- Control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      smp_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) smp_cnt <= smp_cnt + 1'b1;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && smp_cnt == '1) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == BAND_W'(LEVELS)) state_nxt = READOUT;
      end
      READOUT: begin
        out_valid = 1'b1;
        if (frame_done) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // ---------------- Output beat registers ----------------
  function automatic int band_log2(input logic [BAND_W-1:0] k);
    return (k < BAND_W'(LEVELS)) ? WIN_LOG2 - int'(k) - 1 : WIN_LOG2 - LEVELS;
  endfunction

  logic [BAND_W-1:0]       sel_idx;
  logic signed [SUM_W-1:0] sel_mean;
  logic                    load_beat;

  assign sel_idx   = (state == READOUT) ? out_band + BAND_W'(1) : '0;
  assign sel_mean  = acc_sum[sel_idx] >>> band_log2(sel_idx);
  assign load_beat = (state == SETTLE && state_nxt == READOUT) || (beat_done && !out_last);

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      out_band <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_sum  <= '0;
      out_mean <= '0;
      out_last <= 1'b0;
`ifdef DWT_ABS_SUM_EN
      out_abs_sum <= '0;
`endif
    end else if (load_beat) begin
      out_band <= sel_idx;
      out_max  <= acc_max[sel_idx];
      out_min  <= acc_min[sel_idx];
      out_sum  <= acc_sum[sel_idx];
      out_mean <= sel_mean[DATA_W-1:0];
      out_last <= (sel_idx == BAND_W'(LEVELS));
`ifdef DWT_ABS_SUM_EN
      out_abs_sum <= acc_abs[sel_idx];
`endif
    end
  end

endmodule

// File: tb/tb_dwt_band_feature_engine.sv
// Scoreboard bench for dwt_band_feature_engine: a reference Haar model pushes
// expected band beats per frame; readout pops and compares them.
module tb_dwt_band_feature_engine;
  localparam int DATA_W = 32, LEVELS = 4, WIN_LOG2 = 7;
  localparam int SUM_W = DATA_W + WIN_LOG2, BAND_W = 3;
  localparam int WIN = 128, NB = LEVELS + 1;

  logic                     clk = 1'b0;
  logic                     rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [DATA_W-1:0] in_data, out_max, out_min, out_mean;
  logic signed [SUM_W-1:0]  out_sum;
  logic [BAND_W-1:0]        out_band;
`ifdef DWT_ABS_SUM_EN
  logic [SUM_W-1:0]         out_abs_sum;
`endif

  dwt_band_feature_engine #(.DATA_W(DATA_W), .LEVELS(LEVELS), .WIN_LOG2(WIN_LOG2), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_band(out_band), .out_max(out_max),
    .out_min(out_min), .out_sum(out_sum), .out_mean(out_mean), .out_last(out_last)
`ifdef DWT_ABS_SUM_EN
    , .out_abs_sum(out_abs_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BAND_W-1:0]        band;
    logic signed [DATA_W-1:0] mx, mn, mean;
    logic signed [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]         abs_sum;
    logic                     last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic signed [DATA_W-1:0] frm [WIN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference Haar decomposition of frm[], one expected beat per band.
  task automatic model_push();
    longint cur[WIN];
    longint nxt[WIN];
    longint coef[WIN];
    longint mx, mn, sm, ab, c;
    int n, nc;
    exp_t e;
    n = WIN;
    for (int i = 0; i < WIN; i++) cur[i] = frm[i];
    for (int l = 0; l <= LEVELS; l++) begin
      if (l < LEVELS) begin
        n = n / 2;
        for (int i = 0; i < n; i++) begin
          nxt[i]  = (cur[2*i] + cur[2*i+1]) >>> 1;
          coef[i] = (cur[2*i] - cur[2*i+1]) >>> 1;
        end
      end else begin
        for (int i = 0; i < n; i++) coef[i] = cur[i];
      end
      nc = n;
      mx = coef[0]; mn = coef[0]; sm = 0; ab = 0;
      for (int i = 0; i < nc; i++) begin
        c = coef[i];
        if (c > mx) mx = c;
        if (c < mn) mn = c;
        sm += c;
        if (c == -64'sd2147483648) ab += 64'sd2147483647;
        else ab += (c < 0) ? -c : c;
      end
      e.band    = BAND_W'(l);
      e.mx      = mx[DATA_W-1:0];
      e.mn      = mn[DATA_W-1:0];
      e.sum     = sm[SUM_W-1:0];
      c         = sm >>> $clog2(nc);
      e.mean    = c[DATA_W-1:0];
      e.abs_sum = ab[SUM_W-1:0];
      e.last    = (l == LEVELS);
      sb.push_back(e);
      if (l < LEVELS) for (int i = 0; i < n; i++) cur[i] = nxt[i];
    end
  endtask

  task automatic send_frame(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gap > 0 && (i % gap) == gap - 1) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frm[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic check_beat(input string tag, input exp_t e);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_band"}, out_band, e.band);
    chk({tag, "_max"}, out_max, e.mx);
    chk({tag, "_min"}, out_min, e.mn);
    chk({tag, "_sum"}, out_sum, e.sum);
    chk({tag, "_mean"}, out_mean, e.mean);
    chk({tag, "_last"}, out_last, e.last);
`ifdef DWT_ABS_SUM_EN
    chk({tag, "_abs_sum"}, out_abs_sum, e.abs_sum);
`endif
  endtask

  // Called at the negedge right after the last sample was accepted.
  task automatic drain(input bit pulse, input int bp_band);
    int w;
    exp_t e;
    w = 0;
    while (!out_valid && w < 40) begin
      if (pulse) begin
        chk("in_ready_settle", in_ready, 0);
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
    chk("latency", w, LEVELS + 1);
    for (int b = 0; b < NB; b++) begin
      e = sb.pop_front();
      check_beat("beat", e);
      chk("in_ready_readout", in_ready, 0);
      if (b == bp_band) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_beat("hold", e);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("out_valid_after", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_band", out_band, 0);
    chk("rst_max", out_max, 0);
    chk("rst_min", out_min, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_mean", out_mean, 0);
    chk("rst_last", out_last, 0);
    rst = 1'b0;

    // constant 100
    for (int i = 0; i < WIN; i++) frm[i] = 100;
    model_push(); send_frame(WIN, 0); drain(0, -1);

    // alternating +1000/-1000
    for (int i = 0; i < WIN; i++) frm[i] = (i % 2 == 0) ? 1000 : -1000;
    model_push(); send_frame(WIN, 0); drain(0, -1);

    // ramp with input gaps
    for (int i = 0; i < WIN; i++) frm[i] = i;
    model_push(); send_frame(WIN, 7); drain(0, -1);

    // floor rounding on (-3, 0)
    for (int i = 0; i < WIN; i++) frm[i] = 0;
    frm[0] = -3;
    model_push(); send_frame(WIN, 0); drain(0, -1);

    // ignored in_valid during settle/readout plus band-2 backpressure
    for (int i = 0; i < WIN; i++) frm[i] = 100;
    model_push(); send_frame(WIN, 0); drain(1, 2);

    // full-range random samples
    for (int i = 0; i < WIN; i++) frm[i] = $urandom;
    frm[0] = 32'sh7fffffff; frm[1] = -32'sh7fffffff - 1;
    model_push(); send_frame(WIN, 3); drain(0, 4);

    // reset mid-frame, then a clean constant frame
    for (int i = 0; i < WIN; i++) frm[i] = -777;
    send_frame(50, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < WIN; i++) frm[i] = 100;
    model_push(); send_frame(WIN, 0); drain(0, -1);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dwt_band_feature_engine.md
Name: dwt_band_feature_engine

Overview:
- Parametrised successor to the fixed 5-band DWT feature block.
- Streams signed preprocessed EEG samples through a LEVELS-deep Haar (Mallat) cascade over non-overlapping windows of 2^WIN_LOG2 samples.
- Accumulates max/min/sum/mean per band (d1..dLEVELS, then aLEVELS).
- Emits one feature beat per band over a valid/ready stream to the classifier front end.

Parameters:
DATA_W, 32, sample and coefficient width (signed)
LEVELS, 4, decomposition levels; NUM_BANDS = LEVELS+1
WIN_LOG2, 7, log2 of window length; must satisfy WIN_LOG2 > LEVELS
SUM_W, DATA_W+WIN_LOG2, accumulator width (signed)
BAND_W, $clog2(LEVELS+1), band index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_data  in  DATA_W  signed sample
out_valid  out  1  feature beat valid
out_ready  in  1  downstream accept
out_band  out  BAND_W  0=d1 (gamma) .. LEVELS-1=dLEVELS, LEVELS=aLEVELS (delta)
out_max  out  DATA_W  band maximum coefficient
out_min  out  DATA_W  band minimum coefficient
out_sum  out  SUM_W  band coefficient sum
out_mean  out  DATA_W  band mean
out_last  out  1  high on the band-LEVELS beat

Behaviour:
- Reset (clk edge with rst=1): state ACCUM, all counters/accumulators/pair registers cleared, in_ready=1, out_valid=0, out_band=0, all data outputs 0, out_last=0. Reset mid-frame or mid-readout discards the frame.
- Haar stage l (l=1..LEVELS): pairs consecutive inputs x0,x1.
  - a=(x0+x1)>>>1 and d=(x0-x1)>>>1, computed at DATA_W+1 bits, arithmetic shift (floor), truncated to DATA_W.
  - Outputs registered: valid one cycle after the second input of a pair.
  - a feeds stage l+1. Stage LEVELS's a feeds band LEVELS.
- Per-band accumulator:
  - The first coefficient of the frame loads max=min=sum=coef. Later coefficients update max/min with signed compare and add sign-extended into sum.
  - Band k<LEVELS receives 2^(WIN_LOG2-k-1) coefficients. Band LEVELS receives 2^(WIN_LOG2-LEVELS).
- Mean = sum >>> log2(band count), truncated to DATA_W. No rounding.
- FSM:
  - ACCUM: in_ready=1, sample counter increments per handshake. On acceptance of sample 2^WIN_LOG2-1 (the last of the window) -> SETTLE.
  - SETTLE: in_ready=0, counts LEVELS cycles for the cascade to drain, then -> READOUT.
  - READOUT: in_ready=0, out_valid=1, out_band starts at 0.
    - On out_valid&&out_ready, out_band increments.
    - When the band LEVELS beat (out_last=1) is accepted -> ACCUM, with accumulators and pair registers cleared in the same cycle.
- Latency: last sample accepted at edge T gives out_valid=1 after edge T+LEVELS+1.
- Backpressure: while out_valid && !out_ready, all out_* hold stable.
- in_valid is ignored while in_ready=0. in_data is don't-care when in_valid=0. Gaps in in_valid stall the counters without affecting results.
- out_sum cannot overflow given SUM_W. Narrower SUM_W overrides wrap modulo 2^SUM_W.

Optional Feature:
- Macro: DWT_ABS_SUM_EN.
- Defined:
  - Adds output port out_abs_sum (SUM_W): sum of |coef| per band, accumulated alongside sum.
  - |most-negative| saturates to 2^(DATA_W-1)-1.
  - Reset value 0; holds under backpressure like the other out_* ports.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Default params, 128 samples of constant 100 -> bands 0-3: max=min=sum=mean=0. Band 4: max=min=mean=100, sum=800, out_last=1.
- Alternating +1000,-1000 (x[0]=+1000) -> band 0: max=min=mean=1000, sum=64000. Bands 1-4: all zero.
- Ramp x[n]=n, n=0..127 -> band 0: max=min=mean=-1, sum=-64. Floor check: pair (-3,0) in a separate window gives a1=-2, d1=-2.
- Constant frame, last sample at edge T -> out_valid rises after edge T+5. in_ready=0 from T+1 until the band-4 beat is accepted; in_valid pulses in that interval are ignored.
- Backpressure: out_ready=0 for 5 cycles on the band-2 beat -> out_band=2 and all fields stable. Exactly 5 beats total, out_last only on band 4.
- Reset after 50 samples, then a full constant-100 frame -> results identical to the first scenario. With DWT_ABS_SUM_EN, alternating ±1000 gives band-0 out_abs_sum=64000.
